// File: rtl/apb_timer.sv
// apb_timer: 32-bit down-counting APB timer with an 8-bit prescaler,
// periodic or one-shot reload and a maskable level interrupt.
module apb_timer #(
    parameter int DW  = 32,
    parameter int AW  = 12,
    parameter int PSW = 8
) (
    input  logic          pclk,
    input  logic          prst,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic [DW-1:0] prdata,
    output logic          pready,
    output logic          pslverr,
    output logic          timer_irq
);
    localparam int WW = AW - 2;

    logic           r_enable;
    logic           r_irq_en;
    logic           r_periodic;
    logic [PSW-1:0] r_prescale;
    logic [PSW-1:0] r_pcnt;
    logic [DW-1:0]  r_load;
    logic [DW-1:0]  r_value;
    logic           r_irq_raw;

    logic [WW-1:0]  w_word;
    logic           w_sel_ctrl, w_sel_load, w_sel_value, w_sel_stat, w_mapped;
    logic           w_wr, w_wr_ctrl, w_wr_load, w_wr_stat;
    logic           w_tick, w_expire, w_tick_upd, w_start;
    logic           w_unused;

    assign w_word      = paddr[AW-1:2];
    assign w_unused    = ^paddr[1:0];
    assign w_sel_ctrl  = (w_word == WW'(0));
    assign w_sel_load  = (w_word == WW'(1));
    assign w_sel_value = (w_word == WW'(2));
    assign w_sel_stat  = (w_word == WW'(3));
    assign w_mapped    = w_sel_ctrl | w_sel_load | w_sel_value | w_sel_stat;

    assign w_wr      = psel & penable & pwrite;
    assign w_wr_ctrl = w_wr & w_sel_ctrl;
    assign w_wr_load = w_wr & w_sel_load;
    assign w_wr_stat = w_wr & w_sel_stat;

    // A register write in the tick cycle wins over the tick's VALUE/enable update,
    // but the interrupt still latches so an expiry is never silently lost.
    assign w_tick     = r_enable & (r_pcnt == r_prescale);
    assign w_expire   = w_tick & (r_value == DW'(1));
    assign w_tick_upd = w_tick & ~w_wr_ctrl & ~w_wr_load;
    assign w_start    = w_wr_ctrl & ~r_enable & pwdata[0];

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            r_enable   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_periodic <= 1'b0;
            r_prescale <= '0;
            r_pcnt     <= '0;
            r_load     <= '0;
            r_value    <= '0;
            r_irq_raw  <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_enable   <= pwdata[0];
                r_irq_en   <= pwdata[1];
                r_periodic <= pwdata[2];
                r_prescale <= pwdata[4 +: PSW];
            end else if (w_tick_upd && w_expire && !r_periodic) begin
                r_enable <= 1'b0;
            end

            if (w_wr_load) begin
                r_load <= pwdata;
            end

            if (w_wr_load) begin
                r_value <= pwdata;
            end else if (w_tick_upd) begin
                if (w_expire) begin
                    r_value <= r_periodic ? r_load : '0;
                end else if (r_value != '0) begin
                    r_value <= r_value - DW'(1);
                end
            end

            if (w_wr_load || w_start) begin
                r_pcnt <= '0;
            end else if (r_enable) begin
                r_pcnt <= w_tick ? '0 : r_pcnt + PSW'(1);
            end

            if (w_expire) begin
                r_irq_raw <= 1'b1;
            end else if (w_wr_stat && pwdata[0]) begin
                r_irq_raw <= 1'b0;
            end
        end
    end

    always_comb begin
        prdata = '0;
        if (psel && !pwrite) begin
            if (w_sel_ctrl) begin
                prdata[0]         = r_enable;
                prdata[1]         = r_irq_en;
                prdata[2]         = r_periodic;
                prdata[4 +: PSW]  = r_prescale;
            end else if (w_sel_load) begin
                prdata = r_load;
            end else if (w_sel_value) begin
                prdata = r_value;
            end else if (w_sel_stat) begin
                prdata[0] = r_irq_raw;
            end
        end
    end

    assign pready    = 1'b1;
    assign pslverr   = psel & penable & (~w_mapped | (pwrite & w_sel_value));
    assign timer_irq = r_irq_raw & r_irq_en;
endmodule

// File: tb/tb_apb_timer.sv
// Directed self-checking bench for apb_timer: reset, periodic, one-shot,
// error responses, simultaneous events and asynchronous reset.
module tb_apb_timer;
    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int PSW = 8;
    localparam logic [AW-1:0] A_CTRL  = 12'h000;
    localparam logic [AW-1:0] A_LOAD  = 12'h004;
    localparam logic [AW-1:0] A_VALUE = 12'h008;
    localparam logic [AW-1:0] A_STAT  = 12'h00C;

    logic          pclk = 1'b0;
    logic          prst = 1'b1;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic          timer_irq;

    int n_checks = 0;
    int n_fail   = 0;

    apb_timer #(.DW(DW), .AW(AW), .PSW(PSW)) dut (
        .pclk(pclk), .prst(prst), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .timer_irq(timer_irq)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
        $fatal(1);
    end

    // Commit edge is the posedge just before the task returns.
    task automatic apb_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        #1 err = pslverr;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge pclk);
        penable = 1'b1;
        #1 d = prdata; err = pslverr;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset;
        logic [AW-1:0] addrs [4];
        logic [DW-1:0] d;
        logic e;
        addrs[0] = A_CTRL; addrs[1] = A_LOAD; addrs[2] = A_VALUE; addrs[3] = A_STAT;
        repeat (2) @(negedge pclk);
        #1;
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", timer_irq); end
        n_checks++; if (pready !== 1'b1) begin n_fail++; $display("FAIL rst_pready: got %b want 1", pready); end
        n_checks++; if (prdata !== '0) begin n_fail++; $display("FAIL rst_prdata: got %h want 0", prdata); end
        n_checks++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL rst_pslverr: got %b want 0", pslverr); end
        @(negedge pclk);
        prst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apb_read(addrs[i], d, e);
            n_checks++; if (d !== '0) begin n_fail++; $display("FAIL rst_read[%0d]: got %h want 0", i, d); end
            n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL rst_read_err[%0d]: got %b want 0", i, e); end
        end
    endtask

    task automatic test_periodic;
        logic [DW-1:0] exp_v [6];
        logic e;
        exp_v[0] = 5; exp_v[1] = 4; exp_v[2] = 3; exp_v[3] = 2; exp_v[4] = 1; exp_v[5] = 5;
        apb_write(A_LOAD, 32'd5, e);
        apb_write(A_CTRL, 32'h7, e);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = A_VALUE;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_checks++; if (prdata !== exp_v[k]) begin n_fail++; $display("FAIL per_value[%0d]: got %0d want %0d", k, prdata, exp_v[k]); end
            n_checks++; if (timer_irq !== (k == 5)) begin n_fail++; $display("FAIL per_irq[%0d]: got %b want %b", k, timer_irq, (k == 5)); end
            @(negedge pclk);
        end
        apb_write(A_STAT, 32'h1, e);
        #1;
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL per_clear: got %b want 0", timer_irq); end
        @(negedge pclk); #1;
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL per_pre_irq2: got %b want 0", timer_irq); end
        @(negedge pclk); #1;
        n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL per_irq2: got %b want 1", timer_irq); end
        @(negedge pclk);
        apb_write(A_CTRL, 32'h0, e);
        apb_write(A_STAT, 32'h1, e);
    endtask

    task automatic test_oneshot;
        logic [DW-1:0] d;
        logic [DW-1:0] want;
        logic e;
        apb_write(A_LOAD, 32'd3, e);
        apb_write(A_CTRL, 32'h33, e);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = A_VALUE;
        for (int k = 0; k < 14; k++) begin
            #1;
            want = (k < 12) ? DW'(3 - k / 4) : '0;
            n_checks++; if (prdata !== want) begin n_fail++; $display("FAIL os_value[%0d]: got %0d want %0d", k, prdata, want); end
            n_checks++; if (timer_irq !== (k >= 12)) begin n_fail++; $display("FAIL os_irq[%0d]: got %b want %b", k, timer_irq, (k >= 12)); end
            @(negedge pclk);
        end
        psel = 1'b0; penable = 1'b0;
        apb_read(A_CTRL, d, e);
        n_checks++; if (d !== 32'h32) begin n_fail++; $display("FAIL os_ctrl: got %h want 32", d); end
        apb_write(A_STAT, 32'h1, e);
        repeat (20) @(negedge pclk);
        #1;
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL os_no_irq: got %b want 0", timer_irq); end
        apb_read(A_VALUE, d, e);
        n_checks++; if (d !== '0) begin n_fail++; $display("FAIL os_value_idle: got %0d want 0", d); end
        apb_read(A_STAT, d, e);
        n_checks++; if (d !== '0) begin n_fail++; $display("FAIL os_stat_idle: got %h want 0", d); end
    endtask

    task automatic test_errors;
        logic [DW-1:0] d;
        logic e;
        apb_write(A_VALUE, 32'h1234, e);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_wr_value: got %b want 1", e); end
        apb_read(A_VALUE, d, e);
        n_checks++; if (d !== '0) begin n_fail++; $display("FAIL err_value_kept: got %h want 0", d); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL err_rd_value: got %b want 0", e); end
        apb_read(12'h010, d, e);
        n_checks++; if (d !== '0) begin n_fail++; $display("FAIL err_rd010_data: got %h want 0", d); end
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_rd010: got %b want 1", e); end
        apb_write(12'h010, 32'hFFFF_FFFF, e);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_wr010: got %b want 1", e); end
        apb_write(12'hFFC, 32'hFFFF_FFFF, e);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_wrffc: got %b want 1", e); end
        apb_read(12'hFFC, d, e);
        n_checks++; if (d !== '0) begin n_fail++; $display("FAIL err_rdffc_data: got %h want 0", d); end
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_rdffc: got %b want 1", e); end
        apb_read(12'h007, d, e);
        n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL err_bytebits_load: got %h want 3", d); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL err_bytebits_err: got %b want 0", e); end
        apb_read(A_CTRL, d, e);
        n_checks++; if (d !== 32'h32) begin n_fail++; $display("FAIL err_ctrl_kept: got %h want 32", d); end
        apb_read(A_STAT, d, e);
        n_checks++; if (d !== '0) begin n_fail++; $display("FAIL err_stat_kept: got %h want 0", d); end
        apb_write(A_CTRL, 32'h32, e);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL err_wr_ctrl_ok: got %b want 0", e); end
    endtask

    task automatic test_collisions;
        logic [DW-1:0] d;
        logic e;
        apb_write(A_CTRL, 32'h0, e);
        apb_write(A_LOAD, 32'd2, e);
        apb_write(A_CTRL, 32'h7, e);
        // With prescale 0, the INTSTAT clear commits on the second tick: the expiry.
        apb_write(A_STAT, 32'h1, e);
        #1;
        n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL col_set_wins: got %b want 1", timer_irq); end
        apb_read(A_STAT, d, e);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL col_stat: got %h want 1", d); end
        apb_write(A_LOAD, 32'd9, e);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = A_VALUE;
        #1;
        n_checks++; if (prdata !== 32'd9) begin n_fail++; $display("FAIL col_load_wins: got %0d want 9", prdata); end
        @(negedge pclk); #1;
        n_checks++; if (prdata !== 32'd8) begin n_fail++; $display("FAIL col_after_load: got %0d want 8", prdata); end
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        apb_write(A_CTRL, 32'h0, e);
        apb_write(A_STAT, 32'h1, e);
    endtask

    task automatic test_reset_mid;
        logic [AW-1:0] addrs [4];
        logic [DW-1:0] d;
        logic e;
        int waited;
        addrs[0] = A_CTRL; addrs[1] = A_LOAD; addrs[2] = A_VALUE; addrs[3] = A_STAT;
        apb_write(A_LOAD, 32'd5, e);
        apb_write(A_CTRL, 32'h7, e);
        waited = 0;
        #1;
        while (timer_irq !== 1'b1 && waited < 20) begin
            @(negedge pclk); #1;
            waited++;
        end
        n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL rm_irq_timeout: got %b want 1 within 20 cycles", timer_irq); end
        #1 prst = 1'b1;
        #1;
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL rm_async_drop: got %b want 0", timer_irq); end
        @(negedge pclk);
        prst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apb_read(addrs[i], d, e);
            n_checks++; if (d !== '0) begin n_fail++; $display("FAIL rm_read[%0d]: got %h want 0", i, d); end
        end
        repeat (8) @(negedge pclk);
        #1;
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL rm_idle_irq: got %b want 0", timer_irq); end
    endtask

    initial begin
        test_reset;
        test_periodic;
        test_oneshot;
        test_errors;
        test_collisions;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
